// File: rtl/alu_ctrl.sv
// Multi-cycle controller for an external combinational 16-bit ALU: fetch, execute, halt.
// Optional debug read port enabled by defining ALU_CTRL_DBG_EN.
module alu_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic [2:0]  alu_op,
    output logic [15:0] alu_ina,
    output logic [15:0] alu_inb,
    output logic [15:0] alu_inc,
    input  logic [15:0] alu_out,
    output logic [15:0] pc,
    output logic        halted
`ifdef ALU_CTRL_DBG_EN
    ,
    input  logic [2:0]  dbg_sel,
    output logic [15:0] dbg_data
`endif
);

    localparam int unsigned DW   = 16;
    localparam int unsigned RW   = 3;
    localparam int unsigned NREG = 8;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_NOT  = 3'b010;
    localparam logic [2:0] OP_JMPA = 3'b011;
    localparam logic [2:0] OP_JMPB = 3'b100;
    localparam logic [2:0] OP_ADD  = 3'b101;
    localparam logic [2:0] OP_BRR  = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    typedef struct packed {
        logic [RW-1:0] op;
        logic [RW-1:0] rd;
        logic [RW-1:0] ra;
        logic [RW-1:0] rb;
        logic [RW-1:0] rc;
        logic          spare;
    } instr_t;

    state_t          state;
    state_t          state_nx;
    instr_t          ir;
    logic [DW-1:0]   rf [NREG];
    logic [DW-1:0]   ra_val;
    logic [DW-1:0]   rb_val;
    logic [DW-1:0]   rc_val;
    logic [DW-1:0]   pc_nx;
    logic            pc_we;
    logic            rf_we;
    logic            unused_spare;

    assign unused_spare = ir.spare;

    // R0 is hard-wired to zero on every read path
    always_comb begin
        ra_val = (ir.ra == '0) ? '0 : rf[ir.ra];
        rb_val = (ir.rb == '0) ? '0 : rf[ir.rb];
        rc_val = (ir.rc == '0) ? '0 : rf[ir.rc];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_FETCH: if (mem_ack) state_nx = S_EXEC;
            S_EXEC:  state_nx = (ir.op == OP_HALT) ? S_HALT : S_FETCH;
            S_HALT:  state_nx = S_HALT;
            default: state_nx = S_FETCH;
        endcase
    end

    // Bus/ALU drive and datapath write enables per state
    always_comb begin
        mem_req  = 1'b0;
        mem_addr = pc;
        alu_op   = OP_HALT;
        alu_ina  = '0;
        alu_inb  = '0;
        alu_inc  = '0;
        halted   = 1'b0;
        pc_we    = 1'b0;
        pc_nx    = pc;
        rf_we    = 1'b0;
        unique case (state)
            S_FETCH: mem_req = 1'b1;
            S_EXEC: begin
                alu_op = ir.op;
                case (ir.op)
                    OP_AND, OP_OR, OP_NOT, OP_ADD: begin
                        alu_ina = ra_val;
                        alu_inb = rb_val;
                        rf_we   = (ir.rd != '0);
                        pc_we   = 1'b1;
                        pc_nx   = pc + 16'd1;
                    end
                    OP_JMPA, OP_JMPB, OP_BRR: begin
                        alu_ina = pc;
                        alu_inb = rb_val;
                        alu_inc = rc_val;
                        pc_we   = 1'b1;
                        pc_nx   = alu_out;
                    end
                    default: ;
                endcase
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= '0;
            ir <= '0;
            for (int unsigned i = 0; i < NREG; i++) rf[RW'(i)] <= '0;
        end else begin
            if (state == S_FETCH && mem_ack) ir <= instr_t'(mem_rdata);
            if (pc_we) pc <= pc_nx;
            if (rf_we) rf[ir.rd] <= alu_out;
        end
    end

`ifdef ALU_CTRL_DBG_EN
    always_comb begin
        dbg_data = (dbg_sel == '0) ? '0 : rf[dbg_sel];
    end
`endif

endmodule

// File: tb/tb_alu_ctrl.sv
// Directed bench for alu_ctrl: instruction-level reference model, external ALU model,
// per-cycle output comparison plus hand-computed spot checks.
module tb_alu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [2:0]  alu_op;
    logic [15:0] alu_ina, alu_inb, alu_inc, alu_out;
    logic [15:0] pc;
    logic        halted;
`ifdef ALU_CTRL_DBG_EN
    logic [2:0]  dbg_sel;
    logic [15:0] dbg_data;
`endif

    logic [15:0] mem [0:65535];
    int          n_pass = 0;
    int          n_total = 0;
    logic        chk_en = 1'b0;

    alu_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .alu_op(alu_op), .alu_ina(alu_ina), .alu_inb(alu_inb), .alu_inc(alu_inc),
        .alu_out(alu_out), .pc(pc), .halted(halted)
`ifdef ALU_CTRL_DBG_EN
        , .dbg_sel(dbg_sel), .dbg_data(dbg_data)
`endif
    );

    always #5 clk = ~clk;

    // Combinational ALU: 011 jumps to b when c!=0, 100 jumps to b when c==0,
    // 110 branches to a+b when c!=0; untaken jumps fall through to a+1.
    function automatic logic [15:0] alu_f(input logic [2:0] op, input logic [15:0] a,
                                          input logic [15:0] b, input logic [15:0] c);
        case (op)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return ~a;
            3'b011:  return (c != 16'd0) ? b : 16'(a + 16'd1);
            3'b100:  return (c == 16'd0) ? b : 16'(a + 16'd1);
            3'b101:  return 16'(a + b);
            3'b110:  return (c != 16'd0) ? 16'(a + b) : 16'(a + 16'd1);
            default: return 16'd0;
        endcase
    endfunction

    assign alu_out   = alu_f(alu_op, alu_ina, alu_inb, alu_inc);
    assign mem_rdata = mem[mem_addr];

    function automatic logic [15:0] enc(input int op, input int rd, input int ra,
                                        input int rb, input int rc);
        return 16'((op << 13) | (rd << 10) | (ra << 7) | (rb << 4) | (rc << 1));
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: architectural state advanced one instruction phase per clock
    typedef enum int {M_FETCH, M_EXEC, M_HALT} mphase_t;
    mphase_t     m_ph;
    logic [15:0] m_pc, m_ir;
    logic [15:0] m_r [0:7];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ph = M_FETCH;
            m_pc = 16'd0;
            m_ir = 16'd0;
            for (int i = 0; i < 8; i++) m_r[i] = 16'd0;
        end else if (m_ph == M_FETCH) begin
            if (mem_ack) begin
                m_ir = mem[m_pc];
                m_ph = M_EXEC;
            end
        end else if (m_ph == M_EXEC) begin
            int op, rd, ra, rb, rc;
            op = int'(m_ir[15:13]); rd = int'(m_ir[12:10]); ra = int'(m_ir[9:7]);
            rb = int'(m_ir[6:4]);   rc = int'(m_ir[3:1]);
            if (op == 7) begin
                m_ph = M_HALT;
            end else if (op == 3 || op == 4 || op == 6) begin
                m_pc = alu_f(3'(op), m_pc, m_r[rb], m_r[rc]);
                m_ph = M_FETCH;
            end else begin
                logic [15:0] v;
                v = alu_f(3'(op), m_r[ra], m_r[rb], 16'd0);
                if (rd != 0) m_r[rd] = v;
                m_pc = m_pc + 16'd1;
                m_ph = M_FETCH;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [2:0] op;
            op = m_ir[15:13];
            chk("mem_req", 16'(mem_req), 16'(m_ph == M_FETCH));
            chk("halted", 16'(halted), 16'(m_ph == M_HALT));
            chk("pc", pc, m_pc);
            if (m_ph == M_FETCH) chk("mem_addr", mem_addr, m_pc);
            chk("alu_op", 16'(alu_op), 16'((m_ph == M_EXEC) ? op : 3'b111));
            if (m_ph != M_EXEC) begin
                chk("alu_in_idle", alu_ina | alu_inb | alu_inc, 16'd0);
            end else if (op == 3'd3 || op == 3'd4 || op == 3'd6) begin
                chk("alu_ina_j", alu_ina, m_pc);
                chk("alu_inb_j", alu_inb, m_r[m_ir[6:4]]);
                chk("alu_inc_j", alu_inc, m_r[m_ir[3:1]]);
            end else if (op != 3'd7) begin
                chk("alu_ina", alu_ina, m_r[m_ir[9:7]]);
                chk("alu_inb", alu_inb, m_r[m_ir[6:4]]);
                chk("alu_inc", alu_inc, 16'd0);
            end
`ifdef ALU_CTRL_DBG_EN
            chk("dbg_data", dbg_data, m_r[dbg_sel]);
`endif
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic run_to(input logic [15:0] a);
        int n = 0;
        while (!(pc == a && mem_req) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            n_total++;
            $display("FAIL run_to: pc=%h never fetched from %h", pc, a);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 65536; i++) mem[i] = 16'd0;
    endtask

    task automatic do_reset();
        @(negedge clk); #3 rst_n = 1'b0;
        @(negedge clk); #3 rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        mem_ack = 1'b1;
`ifdef ALU_CTRL_DBG_EN
        dbg_sel = 3'd3;
`endif
        // Program 1: register build-up, stall, logic ops, jumps, wrap to 0, halt
        clear_mem();
        mem[0]  = 16'hA080;
        mem[1]  = enc(2, 7, 0, 0, 0);
        mem[2]  = enc(5, 6, 7, 7, 0);
        mem[3]  = enc(2, 4, 6, 0, 0);
        mem[4]  = enc(5, 2, 4, 4, 0);
        mem[5]  = enc(5, 2, 2, 4, 0);
        mem[6]  = enc(5, 1, 2, 4, 0);
        mem[7]  = enc(5, 1, 1, 4, 0);
        mem[8]  = 16'hACA0;
        mem[9]  = enc(0, 5, 3, 7, 0);
        mem[10] = enc(1, 5, 5, 4, 0);
        mem[11] = enc(4, 0, 0, 5, 4);
        mem[12] = enc(3, 0, 0, 7, 4);
        mem[16'hFFFF] = enc(5, 5, 3, 4, 0);

        #2 rst_n = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        chk("rst_pc", pc, 16'h0000);
        chk("rst_mem_req", 16'(mem_req), 16'd1);
        chk("rst_halted", 16'(halted), 16'd0);
        chk("rst_alu_op", 16'(alu_op), 16'd7);
        #3 rst_n = 1'b1;
        #1;
        chk("first_mem_addr", mem_addr, 16'h0000);
        chk("first_mem_req", 16'(mem_req), 16'd1);
        @(negedge clk);
        chk("r0_add_op", 16'(alu_op), 16'd5);
        chk("r0_add_noreq", 16'(mem_req), 16'd0);
        @(negedge clk);
        chk("r0_add_pc", pc, 16'h0001);
        mem[0] = 16'hE000;

        run_to(16'd6);
        mem_ack = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("stall_addr", mem_addr, 16'd6);
            chk("stall_req", 16'(mem_req), 16'd1);
        end
        mem_ack = 1'b1;

        run_to(16'd8);
        step(1);
        chk("add_exec_op", 16'(alu_op), 16'd5);
        step(1);
        chk("add_pc", pc, 16'd9);
        chk("add_fetch_op", 16'(alu_op), 16'd7);
        step(1);
        chk("add_r3", alu_ina, 16'd8);

        run_to(16'hFFFF);
        step(2);
        chk("pc_wrap", pc, 16'h0000);
        step(3);
        chk("halt1", 16'(halted), 16'd1);

        // Program 2: conditional jump at pc 4, wrapping relative branch, halt
        clear_mem();
        mem[0]  = enc(2, 7, 0, 0, 0);
        mem[1]  = enc(5, 6, 7, 7, 0);
        mem[2]  = enc(2, 1, 6, 0, 0);
        mem[3]  = enc(5, 2, 1, 1, 0);
        mem[4]  = enc(3, 0, 0, 2, 3);
        mem[5]  = enc(5, 2, 2, 2, 0);
        mem[6]  = enc(5, 4, 2, 0, 0);
        mem[7]  = enc(5, 2, 2, 2, 0);
        mem[8]  = enc(5, 2, 2, 2, 0);
        mem[9]  = enc(3, 0, 0, 4, 1);
        mem[16'h10] = enc(5, 5, 1, 1, 0);
        mem[16'h11] = enc(3, 0, 0, 7, 1);
        mem[16'hFFFF] = enc(6, 0, 0, 5, 1);
        do_reset();

        run_to(16'd4);
        step(2);
        run_to(16'd4);
        step(2);
        chk("j_not_taken", pc, 16'd5);
        mem[5] = enc(5, 3, 1, 0, 0);
        mem[6] = enc(3, 0, 0, 4, 1);
        mem[1] = 16'hE000;
        run_to(16'd4);
        step(2);
        chk("j_taken", pc, 16'h0010);
        run_to(16'hFFFF);
        step(2);
        chk("br_wrap", pc, 16'h0001);
        step(3);
        chk("halt2", 16'(halted), 16'd1);
        chk("halt2_req", 16'(mem_req), 16'd0);
        step(5);
        chk("halt2_stay", 16'(halted), 16'd1);
        chk("halt2_pc", pc, 16'h0001);

        // Program 3: reset pulse in the middle of EXEC
        clear_mem();
        mem[0] = enc(2, 7, 0, 0, 0);
        mem[1] = enc(5, 1, 7, 7, 0);
        mem[2] = 16'hE000;
        do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_pc", pc, 16'h0000);
        chk("abort_req", 16'(mem_req), 16'd1);
        chk("abort_op", 16'(alu_op), 16'd7);
        @(negedge clk); #3 rst_n = 1'b1;
        step(4);
        chk("post_abort_pc", pc, 16'd2);
        step(3);
        chk("halt3", 16'(halted), 16'd1);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu_ctrl.md
ALU_CTRL -- requirements
Module: alu_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; rst_n  in  1  asynchronous active-low reset.
REQ-002 SHALL have ports: mem_req  out  1  fetch request; mem_addr  out  16  fetch address; mem_ack  in  1  fetch complete; mem_rdata  in  16  instruction word.
REQ-003 SHALL have ports: alu_op  out  3; alu_ina, alu_inb, alu_inc  out  16 each; alu_out  in  16 -- drives and consumes the combinational 16-bit ALU (ops 000 AND, 001 OR, 010 NOT, 011/100 conditional jump, 101 ADD, 110 conditional relative branch).
REQ-004 SHALL have ports: pc  out  16  current program counter; halted  out  1  HALT executed.
REQ-005 SHALL have exactly one clock (clk); reset is asynchronous and active-low (rst_n).

Function
REQ-006 SHALL decode instruction IR as op=[15:13], rd=[12:10], ra=[9:7], rb=[6:4], rc=[3:1]; bit 0 ignored.
REQ-007 SHALL hold eight 16-bit registers R0..R7; R0 reads 0 and ignores writes.
REQ-008 SHALL implement states FETCH, EXEC, HALT; reset enters FETCH.
REQ-009 FETCH: mem_req=1, mem_addr=pc combinationally; on a clk edge with mem_ack=1, IR<=mem_rdata and state->EXEC; otherwise remain, with mem_addr held stable.
REQ-010 mem_ack SHALL be ignored outside FETCH.
REQ-011 EXEC, op in {000,001,010,101}: alu_ina=R[ra], alu_inb=R[rb], alu_inc=0; at the edge R[rd]<=alu_out, pc<=pc+1 (mod 2^16), state->FETCH.
REQ-012 EXEC, op in {011,100,110}: alu_ina=pc, alu_inb=R[rb], alu_inc=R[rc]; at the edge pc<=alu_out, no register write, state->FETCH.
REQ-013 EXEC, op 111: no register write, pc unchanged, state->HALT.
REQ-014 alu_op SHALL equal IR op in EXEC and 3'b111 in all other states; alu_ina/inb/inc SHALL be 0 outside EXEC.
REQ-015 HALT: mem_req=0, halted=1; leaves only via reset.
REQ-016 Minimum cost SHALL be 2 cycles per instruction (ack in first FETCH cycle); each extra wait cycle adds 1.
REQ-017 pc wrap: 16'hFFFF+1 -> 16'h0000; branch sums wrap modulo 2^16 (carry discarded).
REQ-018 Register reads in EXEC SHALL see values as of the start of that cycle (rd==ra or rd==rb uses old value).

Reset
REQ-019 rst_n low SHALL immediately force state=FETCH, pc=0, IR=0, R0..R7=0, halted=0.
REQ-020 After reset deassertion, mem_req=1 and mem_addr=0 in the first cycle.
REQ-021 Reset asserted mid-fetch or mid-EXEC SHALL abort the instruction with no register or pc update.

Configuration
REQ-022 Macro ALU_CTRL_DBG_EN, when defined, SHALL add ports dbg_sel  in  3 and dbg_data  out  16, with dbg_data = R[dbg_sel] combinationally (R0 -> 0).
REQ-023 Without ALU_CTRL_DBG_EN, those ports SHALL be absent and behaviour otherwise identical.

Verification
REQ-024 Reset then mem_ack=1 each FETCH with 16'hA080 (ADD R0+... rd=0) -> R0 stays 0, pc 0->1 after 2 cycles.
REQ-025 R1=5, R2=3 preloaded by prior ADDs; ADD rd=3,ra=1,rb=2 (16'hACA0) -> R3=8, pc+1, alu_op=101 during EXEC only.
REQ-026 pc=4, R2=16'h0010, R3=0, op 011 rb=2 rc=3 -> pc=5; same with R3=1 -> pc=16'h0010.
REQ-027 pc=16'hFFFF, op 110 with R[rc]=1, R[rb]=2 -> pc=16'h0001; non-branch at pc=16'hFFFF -> pc=0.
REQ-028 mem_ack held low 3 cycles -> mem_req stays 1, mem_addr constant, no state change; rst_n pulsed low during EXEC -> pc=0, no write.
REQ-029 Fetch 16'hE000 -> halted=1, mem_req=0 forever, mem_ack ignored, until rst_n low.
